// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the fetch PC and issues word requests to a req/gnt + rvalid memory.
// Returned words go into an in-order prefetch FIFO that feeds decode over
// valid/ready. A redirect flushes the FIFO and drops responses still in flight.
// Optional build macro FETCH_BYPASS_EN: when the FIFO is empty and nothing is
// being discarded, a response is presented to decode in the cycle it arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] pq_wr_reg;
    logic [AW-1:0] pq_rd_reg;

    logic [31:0] fifo_pc_reg   [DEPTH];
    logic [31:0] fifo_inst_reg [DEPTH];
    logic [31:0] pq_pc_reg     [DEPTH];

    logic [CW:0] in_flight;
    logic        accept;
    logic        resp;
    logic        drop;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        bypass_take;

    // Credit: words in flight plus words buffered never exceed the FIFO size.
    assign in_flight  = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign mem_req    = rst & ~redirect & (in_flight < DEPTH_C);
    assign mem_addr   = fetch_pc_reg;
    assign accept     = mem_req & mem_gnt;
    // A response with nothing outstanding is spurious and ignored entirely.
    assign resp       = mem_rvalid & (outstanding_reg != '0);
    assign drop       = resp & (discard_reg != '0);
    assign fifo_empty = (count_reg == '0);
    assign pop        = ~fifo_empty & inst_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass_valid;
    // Present a fresh response directly when the FIFO has nothing older.
    assign bypass_valid = resp & ~drop & fifo_empty & ~redirect;
    assign bypass_take  = bypass_valid & inst_ready;
    assign inst_valid   = ~fifo_empty | bypass_valid;
    assign inst         = bypass_valid ? mem_rdata : fifo_inst_reg[rd_ptr_reg];
    assign inst_pc      = bypass_valid ? pq_pc_reg[pq_rd_reg] : fifo_pc_reg[rd_ptr_reg];
`else
    assign bypass_take  = 1'b0;
    assign inst_valid   = ~fifo_empty;
    assign inst         = fifo_inst_reg[rd_ptr_reg];
    assign inst_pc      = fifo_pc_reg[rd_ptr_reg];
`endif

    // Responses arriving in a redirect cycle belong to the old path.
    assign push = resp & ~drop & ~redirect & ~bypass_take;

    // Outstanding count after this cycle's accept and response.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !resp) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!accept && resp) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    // Control state: fetch PC, occupancy, in-flight and discard bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg    <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            pq_wr_reg       <= '0;
            pq_rd_reg       <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (accept) begin
                pq_wr_reg <= pq_wr_reg + 1'b1;
            end
            if (resp) begin
                pq_rd_reg <= pq_rd_reg + 1'b1;
            end
            if (redirect) begin
                fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
                count_reg    <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                // Everything still in flight after this cycle is stale.
                discard_reg  <= outstanding_next;
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (push && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_reg <= count_reg - 1'b1;
                end
                if (drop) begin
                    discard_reg <= discard_reg - 1'b1;
                end
            end
        end
    end

    // Prefetch FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_reg[i]   <= '0;
                fifo_inst_reg[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_reg[wr_ptr_reg]   <= pq_pc_reg[pq_rd_reg];
            fifo_inst_reg[wr_ptr_reg] <= mem_rdata;
        end
    end

    // PC queue: address of each accepted request, popped as responses return.
    always_ff @(posedge clk) begin
        if (accept) begin
            pq_pc_reg[pq_wr_reg] <= fetch_pc_reg;
        end
    end

endmodule
